// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller: sequences IF/ID/EX/MEM/WB over shared memory and ALU,
// counts retired instructions and parks in HALT on ECALL with x17==10.
module multicycle_control_unit #(
  parameter int unsigned OPCODE_WIDTH = 7,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned STATE_WIDTH  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    bcond,
  input  logic                    mem_ready,
  input  logic                    halt_x17,
  output logic                    pc_write,
  output logic [1:0]              pc_source,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic                    reg_write,
  output logic                    mem_to_reg,
  output logic                    pc_to_reg,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic                    is_halted,
  output logic                    instr_done,
  output logic [CNT_WIDTH-1:0]    retired_count,
  output logic [STATE_WIDTH-1:0]  state_out
);

  localparam logic [STATE_WIDTH-1:0] S_IF   = STATE_WIDTH'(0);
  localparam logic [STATE_WIDTH-1:0] S_ID   = STATE_WIDTH'(1);
  localparam logic [STATE_WIDTH-1:0] S_EX   = STATE_WIDTH'(2);
  localparam logic [STATE_WIDTH-1:0] S_MEM  = STATE_WIDTH'(3);
  localparam logic [STATE_WIDTH-1:0] S_WB   = STATE_WIDTH'(4);
  localparam logic [STATE_WIDTH-1:0] S_HALT = STATE_WIDTH'(5);

  localparam logic [OPCODE_WIDTH-1:0] OP_R      = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OP_I      = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = OPCODE_WIDTH'(7'b0100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = OPCODE_WIDTH'(7'b1100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = OPCODE_WIDTH'(7'b1101111);
  localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = OPCODE_WIDTH'(7'b1100111);
  localparam logic [OPCODE_WIDTH-1:0] OP_ECALL  = OPCODE_WIDTH'(7'b1110011);

  logic [STATE_WIDTH-1:0] r_state;
  logic [STATE_WIDTH-1:0] w_next_state;
  logic [CNT_WIDTH-1:0]   r_retired_count;

  logic       w_pc_write;
  logic [1:0] w_pc_source;
  logic       w_i_or_d;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_to_reg;
  logic       w_pc_to_reg;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_is_halted;
  logic       w_instr_done;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IF;
    else       r_state <= w_next_state;
  end

  // Next-state logic; opcode is held stable by the IR, so it is read live
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IF:  if (mem_ready) w_next_state = S_ID;
      S_ID: begin
        if (opcode == OP_ECALL) w_next_state = halt_x17 ? S_HALT : S_IF;
        else                    w_next_state = S_EX;
      end
      S_EX: begin
        if (opcode == OP_R || opcode == OP_I)
          w_next_state = S_WB;
        else if (opcode == OP_LOAD || opcode == OP_STORE)
          w_next_state = S_MEM;
        else
          w_next_state = S_IF;
      end
      S_MEM: if (mem_ready) w_next_state = (opcode == OP_LOAD) ? S_WB : S_IF;
      S_WB:   w_next_state = S_IF;
      S_HALT: w_next_state = S_HALT;
      default: w_next_state = S_IF;
    endcase
  end

  // Output decode per state (Mealy terms on mem_ready, bcond, halt_x17)
  always_comb begin
    w_pc_write   = 1'b0;
    w_pc_source  = 2'b00;
    w_i_or_d     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_pc_to_reg  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_is_halted  = 1'b0;
    w_instr_done = 1'b0;
    case (r_state)
      S_IF: begin
        w_mem_read = 1'b1;
        w_ir_write = mem_ready;
      end
      S_ID: begin
        w_alu_src_b = 2'b10;
        if (opcode == OP_ECALL) begin
          w_instr_done = 1'b1;
          w_pc_write   = ~halt_x17;
        end
      end
      S_EX: begin
        if (opcode == OP_R) begin
          w_alu_src_a = 1'b1;
          w_alu_op    = 2'b10;
        end else if (opcode == OP_I) begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b10;
          w_alu_op    = 2'b10;
        end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b10;
        end else if (opcode == OP_BRANCH) begin
          w_alu_src_a  = 1'b1;
          w_alu_op     = 2'b01;
          w_pc_write   = 1'b1;
          w_pc_source  = bcond ? 2'b01 : 2'b00;
          w_instr_done = 1'b1;
        end else if (opcode == OP_JAL) begin
          w_reg_write  = 1'b1;
          w_pc_to_reg  = 1'b1;
          w_pc_write   = 1'b1;
          w_pc_source  = 2'b01;
          w_instr_done = 1'b1;
        end else if (opcode == OP_JALR) begin
          w_alu_src_a  = 1'b1;
          w_alu_src_b  = 2'b10;
          w_reg_write  = 1'b1;
          w_pc_to_reg  = 1'b1;
          w_pc_write   = 1'b1;
          w_pc_source  = 2'b10;
          w_instr_done = 1'b1;
        end else begin
          w_pc_write   = 1'b1;
          w_instr_done = 1'b1;
        end
      end
      S_MEM: begin
        w_i_or_d    = 1'b1;
        w_mem_read  = (opcode == OP_LOAD);
        w_mem_write = (opcode == OP_STORE);
        if (mem_ready && opcode != OP_LOAD) begin
          w_pc_write   = 1'b1;
          w_instr_done = 1'b1;
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (opcode == OP_LOAD);
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_HALT: w_is_halted = 1'b1;
      default: ;
    endcase
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_WIDTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_retired_count <= '0;
    else if (w_instr_done) r_retired_count <= r_retired_count + CNT_WIDTH'(1);
  end

  // Controls are forced low for the whole time reset is high
  assign pc_write      = ~reset & w_pc_write;
  assign pc_source     = reset ? 2'b00 : w_pc_source;
  assign i_or_d        = ~reset & w_i_or_d;
  assign mem_read      = ~reset & w_mem_read;
  assign mem_write     = ~reset & w_mem_write;
  assign ir_write      = ~reset & w_ir_write;
  assign reg_write     = ~reset & w_reg_write;
  assign mem_to_reg    = ~reset & w_mem_to_reg;
  assign pc_to_reg     = ~reset & w_pc_to_reg;
  assign alu_src_a     = ~reset & w_alu_src_a;
  assign alu_src_b     = reset ? 2'b00 : w_alu_src_b;
  assign alu_op        = reset ? 2'b00 : w_alu_op;
  assign is_halted     = ~reset & w_is_halted;
  assign instr_done    = ~reset & w_instr_done;
  assign retired_count = r_retired_count;
  assign state_out     = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit; counter narrowed to 4 bits to reach wrap.
module tb_multicycle_control_unit;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic          bcond, mem_ready, halt_x17;
  logic          pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic          mem_to_reg, pc_to_reg, alu_src_a, is_halted, instr_done;
  logic [1:0]    pc_source, alu_src_b, alu_op;
  logic [CW-1:0] retired_count;
  logic [2:0]    state_out;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt = '0;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] EC = 7'b1110011, LUI = 7'b0110111;

  // Control-vector field masks
  localparam logic [16:0] PCW = 17'h10000, PCS1 = 17'h04000, PCS2 = 17'h08000;
  localparam logic [16:0] IORD = 17'h02000, MRD = 17'h01000, MWR = 17'h00800, IRW = 17'h00400;
  localparam logic [16:0] RW = 17'h00200, M2R = 17'h00100, P2R = 17'h00080, ASA = 17'h00040;
  localparam logic [16:0] BIMM = 17'h00020, AOPB = 17'h00004, AOPF = 17'h00008;
  localparam logic [16:0] HLT = 17'h00002, DONE = 17'h00001;

  multicycle_control_unit #(.OPCODE_WIDTH(7), .CNT_WIDTH(CW), .STATE_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .mem_ready(mem_ready),
    .halt_x17(halt_x17), .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .is_halted(is_halted), .instr_done(instr_done),
    .retired_count(retired_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ctl();
    return {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
            mem_to_reg, pc_to_reg, alu_src_a, alu_src_b, alu_op, is_halted, instr_done};
  endfunction

  // One clock cycle: apply inputs, check state/controls/count, then advance
  task automatic cyc(input string tag, input logic [6:0] op, input logic rdy, input logic bc,
                     input logic hx, input logic [16:0] exp_ctl, input logic [2:0] exp_st);
    opcode = op; mem_ready = rdy; bcond = bc; halt_x17 = hx;
    #1;
    chk({tag, "_state"}, 32'(state_out), 32'(exp_st));
    chk({tag, "_ctl"}, 32'(ctl()), 32'(exp_ctl));
    chk({tag, "_cnt"}, 32'(retired_count), 32'(exp_cnt));
    @(posedge clk); #1;
    if (exp_ctl[0]) exp_cnt = exp_cnt + CW'(1);
  endtask

  task automatic fetch_decode(input string tag, input logic [6:0] op);
    cyc({tag, "_if"}, op, 1'b1, 1'b0, 1'b0, MRD | IRW, 3'd0);
    cyc({tag, "_id"}, op, 1'b0, 1'b0, 1'b0, BIMM, 3'd1);
  endtask

  initial begin
    reset = 1'b1; opcode = R; mem_ready = 1'b1; bcond = 1'b0; halt_x17 = 1'b0;
    @(posedge clk); #1;
    chk("rst_ctl", 32'(ctl()), 32'h0);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_cnt", 32'(retired_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // R-type: IF, ID, EX, WB
    fetch_decode("r", R);
    cyc("r_ex", R, 1'b1, 1'b0, 1'b0, ASA | AOPF, 3'd2);
    cyc("r_wb", R, 1'b1, 1'b0, 1'b0, RW | PCW | DONE, 3'd4);
    chk("r_ret", 32'(retired_count), 32'd1);

    // IF wait on mem_ready, then I-type
    cyc("if_wait", I, 1'b0, 1'b0, 1'b0, MRD, 3'd0);
    fetch_decode("i", I);
    cyc("i_ex", I, 1'b0, 1'b0, 1'b0, ASA | BIMM | AOPF, 3'd2);
    cyc("i_wb", I, 1'b0, 1'b0, 1'b0, RW | PCW | DONE, 3'd4);

    // LOAD with 3 wait cycles in MEM: 8 cycles total
    fetch_decode("ld", LD);
    cyc("ld_ex", LD, 1'b0, 1'b0, 1'b0, ASA | BIMM, 3'd2);
    for (int k = 0; k < 3; k++) cyc("ld_memw", LD, 1'b0, 1'b0, 1'b0, IORD | MRD, 3'd3);
    cyc("ld_mem", LD, 1'b1, 1'b0, 1'b0, IORD | MRD, 3'd3);
    cyc("ld_wb", LD, 1'b0, 1'b0, 1'b0, RW | M2R | PCW | DONE, 3'd4);
    chk("ld_ret", 32'(retired_count), 32'd3);

    // STORE with one wait cycle
    fetch_decode("st", ST);
    cyc("st_ex", ST, 1'b0, 1'b0, 1'b0, ASA | BIMM, 3'd2);
    cyc("st_memw", ST, 1'b0, 1'b0, 1'b0, IORD | MWR, 3'd3);
    cyc("st_mem", ST, 1'b1, 1'b0, 1'b0, IORD | MWR | PCW | DONE, 3'd3);

    // Branches taken / not taken
    fetch_decode("bt", BR);
    cyc("bt_ex", BR, 1'b0, 1'b1, 1'b0, ASA | AOPB | PCW | PCS1 | DONE, 3'd2);
    fetch_decode("bn", BR);
    cyc("bn_ex", BR, 1'b0, 1'b0, 1'b0, ASA | AOPB | PCW | DONE, 3'd2);

    // Jumps, unknown opcode, ECALL without halt
    fetch_decode("jal", JAL);
    cyc("jal_ex", JAL, 1'b0, 1'b0, 1'b0, RW | P2R | PCW | PCS1 | DONE, 3'd2);
    fetch_decode("jalr", JALR);
    cyc("jalr_ex", JALR, 1'b0, 1'b0, 1'b0, ASA | BIMM | RW | P2R | PCW | PCS2 | DONE, 3'd2);
    fetch_decode("unk", LUI);
    cyc("unk_ex", LUI, 1'b0, 1'b0, 1'b0, PCW | DONE, 3'd2);
    cyc("ec_if", EC, 1'b1, 1'b0, 1'b0, MRD | IRW, 3'd0);
    cyc("ec_id", EC, 1'b0, 1'b0, 1'b0, BIMM | PCW | DONE, 3'd1);
    chk("ec_state", 32'(state_out), 32'd0);
    chk("mix_ret", 32'(retired_count), 32'd10);

    // Reset in MEM with mem_ready high
    fetch_decode("rm", LD);
    cyc("rm_ex", LD, 1'b0, 1'b0, 1'b0, ASA | BIMM, 3'd2);
    mem_ready = 1'b1; reset = 1'b1; #1;
    chk("rm_ctl", 32'(ctl()), 32'h0);
    chk("rm_cnt", 32'(retired_count), 32'd0);
    exp_cnt = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rm_state", 32'(state_out), 32'd0);

    // 16 ECALL retirements wrap the 4-bit counter
    for (int k = 0; k < 15; k++) begin
      cyc("wr_if", EC, 1'b1, 1'b0, 1'b0, MRD | IRW, 3'd0);
      cyc("wr_id", EC, 1'b0, 1'b0, 1'b0, BIMM | PCW | DONE, 3'd1);
    end
    chk("wrap_15", 32'(retired_count), 32'd15);
    cyc("wr_if", EC, 1'b1, 1'b0, 1'b0, MRD | IRW, 3'd0);
    cyc("wr_id", EC, 1'b0, 1'b0, 1'b0, BIMM | PCW | DONE, 3'd1);
    chk("wrap_0", 32'(retired_count), 32'd0);

    // ECALL with x17==10 halts; HALT is sticky regardless of mem_ready
    cyc("h_if", EC, 1'b1, 1'b0, 1'b1, MRD | IRW, 3'd0);
    cyc("h_id", EC, 1'b0, 1'b0, 1'b1, BIMM | DONE, 3'd1);
    for (int k = 0; k < 10; k++) cyc("halt", EC, 1'(k & 1), 1'b1, 1'b1, HLT, 3'd5);
    chk("halt_cnt", 32'(retired_count), 32'd1);

    // Only reset leaves HALT
    reset = 1'b1; #1;
    chk("hr_ctl", 32'(ctl()), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = '0;
    cyc("post_if", R, 1'b1, 1'b0, 1'b0, MRD | IRW, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore/Mealy FSM controller for the multi-cycle RV32I core.
- Replaces the single-cycle opcode decoder.
- Sequences IF/ID/EX/MEM/WB over shared memory and ALU, with a ready handshake on memory accesses.
- Counts retired instructions and latches halt on ECALL with x17==10.

Parameters:
- OPCODE_WIDTH, 7, opcode field width
- CNT_WIDTH, 32, retired-instruction counter width
- STATE_WIDTH, 3, state register width

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- opcode  input  OPCODE_WIDTH  from instruction register
- bcond  input  1  branch-taken flag from ALU
- mem_ready  input  1  memory access complete this cycle
- halt_x17  input  1  register x17 equals 10
- pc_write  output  1  update PC
- pc_source  output  2  00 PC+4, 01 ALUOut register, 10 live ALU result
- i_or_d  output  1  0 instruction address, 1 data address
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  load instruction register
- reg_write  output  1  register file write
- mem_to_reg  output  1  write data from MDR
- pc_to_reg  output  1  write data is PC+4
- alu_src_a  output  1  0 PC, 1 rs1
- alu_src_b  output  2  00 rs2, 01 const 4, 10 immediate
- alu_op  output  2  00 ADD, 01 BRANCH compare, 10 FUNCT decode
- is_halted  output  1  sticky halt
- instr_done  output  1  one-cycle pulse on retire
- retired_count  output  CNT_WIDTH  retired instructions
- state_out  output  STATE_WIDTH  current state

Behaviour:
- State encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
- Reset (async):
  - state=IF, retired_count=0, is_halted=0.
  - While reset is high, every control output is forced 0.
- Any output not listed for a state is 0.
- IF:
  - i_or_d=0, mem_read=1, ir_write=mem_ready.
  - mem_ready=1 -> ID; otherwise stay in IF.
- ID:
  - alu_src_a=0, alu_src_b=10, alu_op=00, so ALUOut=PC+imm.
  - Opcode 1110011 (ECALL): if halt_x17 -> HALT and instr_done=1; else pc_write=1, pc_source=00, instr_done=1 -> IF.
  - All other opcodes -> EX.
- EX, by opcode:
  - 0110011 (R-type): alu_src_a=1, alu_src_b=00, alu_op=10 -> WB.
  - 0010011 (I-type ALU): alu_src_a=1, alu_src_b=10, alu_op=10 -> WB.
  - 0000011 (LOAD) / 0100011 (STORE): alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM.
  - 1100011 (BRANCH): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write=1, pc_source = bcond?01:00, instr_done=1 -> IF.
  - 1101111 (JAL): reg_write=1, pc_to_reg=1, pc_write=1, pc_source=01, instr_done=1 -> IF.
  - 1100111 (JALR): alu_src_a=1, alu_src_b=10, alu_op=00, reg_write=1, pc_to_reg=1, pc_write=1, pc_source=10, instr_done=1 -> IF.
  - Any other opcode: pc_write=1, pc_source=00, instr_done=1, no register or memory write -> IF.
- MEM:
  - i_or_d=1; mem_read=1 for LOAD, mem_write=1 for STORE.
  - Request held stable until mem_ready.
  - LOAD with mem_ready -> WB.
  - STORE with mem_ready: pc_write=1, pc_source=00, instr_done=1 -> IF.
  - mem_ready=0: stay in MEM, no pc_write.
- WB:
  - reg_write=1, mem_to_reg=(opcode==LOAD), pc_write=1, pc_source=00, instr_done=1 -> IF.
- HALT:
  - Absorbing state; is_halted=1; all other outputs 0.
  - Leaves only on reset.
- Counters and handshake signals:
  - retired_count increments on every instr_done cycle and wraps modulo 2^CNT_WIDTH.
  - instr_done, pc_write, ir_write and memory requests are never asserted in HALT.
- opcode is sampled combinationally. The IR holds it stable from ID to instruction end; the FSM does not latch it.
- Reset mid-access (any state) returns to IF next cycle with retired_count=0. A pending mem_ready is ignored.

Test Plan:
- Reset, release, mem_ready=1, opcode=0110011:
  - states IF,ID,EX,WB,IF.
  - reg_write=1 only in WB.
  - instr_done one pulse; retired_count=1.
- LOAD (0000011) with mem_ready low 3 cycles in MEM:
  - mem_read, i_or_d held 4 cycles.
  - WB asserts mem_to_reg=1, reg_write=1.
  - Total 8 cycles to retire.
- BRANCH (1100011): bcond=1 -> pc_source=01, pc_write=1 in EX; bcond=0 -> pc_source=00. Both return to IF after 3 cycles.
- JALR (1100111) -> EX shows pc_to_reg=1, reg_write=1, pc_source=10, alu_src_b=10.
- ECALL with halt_x17=1:
  - ID -> HALT.
  - is_halted=1 sticky over 10 cycles with mem_ready toggling.
  - retired_count unchanged afterwards.
- Preload CNT_WIDTH=4 and retire 16 instructions -> retired_count wraps to 0.
- Reset asserted in MEM with mem_ready=1 -> outputs 0 immediately; state_out=0 after release.
